// File: rtl/udma_tx_cp_pkg.sv
// Shared types for the uDMA Tx control plane: beat size, channel state and channel descriptor.
// Descriptor fields are sized for the widest supported AW/SW; the top masks them down to its parameters.
package udma_tx_cp_pkg;

  localparam int ADDR_MAX = 64;
  localparam int SIZE_MAX = 32;

  typedef enum logic [1:0] {
    DS_BYTE     = 2'd0,
    DS_HALF     = 2'd1,
    DS_WORD     = 2'd2,
    DS_WORD_ALT = 2'd3
  } datasize_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [ADDR_MAX-1:0] addr;
    logic [SIZE_MAX-1:0] left;
    datasize_e           datasize;
    logic                cont;
  } ch_desc_t;

  function automatic logic [3:0] beat_bytes(input datasize_e ds);
    case (ds)
      DS_BYTE: return 4'd1;
      DS_HALF: return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/udma_tx_rr_arb.sv
// Combinational round-robin arbiter: zero latency, searches from ptr_i+1 upward with wrap.
// No backpressure of its own; the caller only samples the grant when its port is free.
module udma_tx_rr_arb #(
  parameter  int N_CH = 4,
  localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o
);

  // Scan from farthest to nearest so the nearest requester after ptr_i wins.
  always_comb begin
    logic [IW-1:0] cidx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    cidx      = '0;
    for (int i = N_CH; i >= 1; i--) begin
      cidx = IW'((int'(ptr_i) + i) % N_CH);
      if (req_i[cidx]) begin
        gnt_o       = '0;
        gnt_o[cidx] = 1'b1;
        gnt_idx_o   = cidx;
      end
    end
  end

endmodule

// File: rtl/udma_tx_cp_ctrl.sv
// N-channel uDMA Tx control plane: first request 2 cycles after start, next request 1 cycle after gnt_i.
// A raised request holds until gnt_i; ch_ready_i gates which channels may enter arbitration.
module udma_tx_cp_ctrl
  import udma_tx_cp_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int AW   = 32,
  parameter  int SW   = 20,
  localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  cfg_start_i,
  input  logic [N_CH-1:0]  cfg_stop_i,
  input  logic [N_CH-1:0]  cfg_cont_i,
  input  logic [N_CH*AW-1:0] cfg_addr_i,
  input  logic [N_CH*SW-1:0] cfg_size_i,
  input  logic [N_CH*2-1:0]  cfg_datasize_i,
  input  logic [N_CH-1:0]  ch_ready_i,
  output logic [N_CH-1:0]  busy_o,
  output logic [N_CH*SW-1:0] bytes_left_o,
  output logic [N_CH-1:0]  eot_o,
  output logic             req_o,
  output logic [IW-1:0]    req_ch_o,
  output logic [AW-1:0]    req_addr_o,
  output logic [1:0]       req_datasize_o,
  input  logic             gnt_i
);

  localparam logic [ADDR_MAX-1:0] ADDR_MASK = (ADDR_MAX'(1) << AW) - ADDR_MAX'(1);

  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic [IW-1:0]   rr_ptr;
  logic [AW-1:0]   ch_addr [N_CH];
  datasize_e       ch_ds   [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_state_e  st;
    ch_desc_t   desc;
    ch_desc_t   cfg_desc;
    logic       eot_q;
    logic       stop_pend;
    logic       held;
    logic       last;
    logic [3:0] bb;
    logic [ADDR_MAX-1:0] addr_nx;

    assign cfg_desc = '{addr:     ADDR_MAX'(cfg_addr_i[c*AW +: AW]),
                        left:     SIZE_MAX'(cfg_size_i[c*SW +: SW]),
                        datasize: datasize_e'(cfg_datasize_i[c*2 +: 2]),
                        cont:     cfg_cont_i[c]};
    assign held    = req_o && (req_ch_o == IW'(c));
    assign bb      = beat_bytes(desc.datasize);
    assign last    = desc.left <= SIZE_MAX'(bb);
    assign addr_nx = (desc.addr + ADDR_MAX'(bb)) & ADDR_MASK;

    // A channel being stopped this cycle must not be loaded onto the port.
    assign elig[c] = (st == ACTIVE) && ch_ready_i[c] && !cfg_stop_i[c] && !held;

    assign busy_o[c]                = (st == ACTIVE);
    assign eot_o[c]                 = eot_q;
    assign bytes_left_o[c*SW +: SW] = desc.left[SW-1:0];
    assign ch_addr[c]               = desc.addr[AW-1:0];
    assign ch_ds[c]                 = desc.datasize;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st        <= IDLE;
        desc      <= '0;
        eot_q     <= 1'b0;
        stop_pend <= 1'b0;
      end else begin
        eot_q <= 1'b0;
        case (st)
          IDLE: begin
            stop_pend <= 1'b0;
            if (cfg_start_i[c] && !cfg_stop_i[c]) begin
              desc <= cfg_desc;
              if (cfg_desc.left == '0) eot_q <= 1'b1;
              else                     st    <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (held && gnt_i) begin
              stop_pend <= 1'b0;
              if (stop_pend || cfg_stop_i[c]) begin
                st <= IDLE;
              end else if (last) begin
                eot_q <= 1'b1;
                if (desc.cont && cfg_desc.left != '0) begin
                  desc <= cfg_desc;
                end else begin
                  desc.left <= '0;
                  st        <= IDLE;
                end
              end else begin
                desc.addr <= addr_nx;
                desc.left <= desc.left - SIZE_MAX'(bb);
              end
            end else if (cfg_stop_i[c]) begin
              // The port cannot retract a held beat; finish the stop when it is granted.
              if (held) stop_pend <= 1'b1;
              else      st        <= IDLE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  udma_tx_rr_arb #(.N_CH(N_CH)) u_arb (
    .req_i     (elig),
    .ptr_i     (rr_ptr),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_o          <= 1'b0;
      req_ch_o       <= '0;
      req_addr_o     <= '0;
      req_datasize_o <= '0;
      rr_ptr         <= IW'(N_CH - 1);
    end else if (req_o) begin
      if (gnt_i) req_o <= 1'b0;
    end else if (|arb_gnt) begin
      req_o          <= 1'b1;
      req_ch_o       <= arb_idx;
      req_addr_o     <= ch_addr[arb_idx];
      req_datasize_o <= ch_ds[arb_idx];
      rr_ptr         <= arb_idx;
    end
  end

endmodule

// File: tb/tb_udma_tx_cp_ctrl.sv
// Bench for udma_tx_cp_ctrl: directed vector table, multi-cycle corner sequences,
// then random traffic against a queue-based reference of per-channel beat lists.
module tb_udma_tx_cp_ctrl;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int SW = 20;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    cfg_start_i, cfg_stop_i, cfg_cont_i, ch_ready_i;
  logic [N*AW-1:0] cfg_addr_i;
  logic [N*SW-1:0] cfg_size_i;
  logic [N*2-1:0]  cfg_datasize_i;
  logic [N-1:0]    busy_o, eot_o;
  logic [N*SW-1:0] bytes_left_o;
  logic            req_o, gnt_i;
  logic [1:0]      req_ch_o;
  logic [AW-1:0]   req_addr_o;
  logic [1:0]      req_datasize_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  udma_tx_cp_ctrl #(.N_CH(N), .AW(AW), .SW(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_cont_i(cfg_cont_i),
    .cfg_addr_i(cfg_addr_i), .cfg_size_i(cfg_size_i), .cfg_datasize_i(cfg_datasize_i),
    .ch_ready_i(ch_ready_i), .busy_o(busy_o), .bytes_left_o(bytes_left_o), .eot_o(eot_o),
    .req_o(req_o), .req_ch_o(req_ch_o), .req_addr_o(req_addr_o),
    .req_datasize_o(req_datasize_o), .gnt_i(gnt_i)
  );

  typedef struct {
    int          ch;
    logic [31:0] addr;
    int          size;
    logic [1:0]  ds;
    int          nbeats;
    logic [31:0] last_addr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  ds;
  } beat_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bbytes(input logic [1:0] ds);
    return (ds == 2'd0) ? 1 : ((ds == 2'd1) ? 2 : 4);
  endfunction

  task automatic set_cfg(input int c, input logic [31:0] a, input int sz,
                         input logic [1:0] ds, input logic cont);
    cfg_addr_i[c*AW +: AW]     = a;
    cfg_size_i[c*SW +: SW]     = SW'(sz);
    cfg_datasize_i[c*2 +: 2]   = ds;
    cfg_cont_i[c]              = cont;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    cfg_start_i = '0;
    cfg_stop_i  = '0;
    cfg_cont_i  = '0;
    gnt_i       = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_req(input int lim);
    int k;
    k = 0;
    while (!req_o && k < lim) begin
      step();
      k++;
    end
    chk("wait_req", req_o, 1);
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy_o != '0 && k < lim) begin
      step();
      k++;
    end
    chk("wait_idle", busy_o, 0);
  endtask

  vec_t  vt [5];
  beat_t q [N][$];
  beat_t bt;
  int    m_left [N];
  int    cnt [N];
  bit    m_req;
  int    m_ch, m_last;
  logic [N-1:0] m_eot, rdy, stv, bvec;
  bit    g;
  int    ci, sz, nb, bsz, n, eots, beats, last_gnt, eot_cyc, exp_left, exp_c;
  logic [31:0] ra, last_addr;
  logic [1:0]  rds;

  initial begin
    vt[0] = '{ch: 0, addr: 32'h1C00_0000, size: 8, ds: 2'd2, nbeats: 2, last_addr: 32'h1C00_0004};
    vt[1] = '{ch: 1, addr: 32'h1C00_0100, size: 5, ds: 2'd1, nbeats: 3, last_addr: 32'h1C00_0104};
    vt[2] = '{ch: 3, addr: 32'h0000_0010, size: 3, ds: 2'd0, nbeats: 3, last_addr: 32'h0000_0012};
    vt[3] = '{ch: 2, addr: 32'hFFFF_FFFC, size: 8, ds: 2'd3, nbeats: 2, last_addr: 32'h0000_0000};
    vt[4] = '{ch: 1, addr: 32'h0000_2000, size: 1, ds: 2'd2, nbeats: 1, last_addr: 32'h0000_2000};

    reset_n = 1'b0;
    cfg_start_i = '0; cfg_stop_i = '0; cfg_cont_i = '0;
    cfg_addr_i = '0; cfg_size_i = '0; cfg_datasize_i = '0;
    ch_ready_i = '1; gnt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_eot", eot_o, 0);
    chk("rst_left", bytes_left_o, 0);
    chk("rst_addr", req_addr_o, 0);
    chk("rst_ch", req_ch_o, 0);
    reset_n = 1'b1;
    step();

    // All four channels, 4 single-byte beats each: strict 0,1,2,3 rotation.
    for (int c = 0; c < N; c++) begin
      set_cfg(c, 32'h100 * c, 4, 2'd0, 1'b0);
      cnt[c] = 0;
    end
    gnt_i = 1'b1;
    cfg_start_i = '1;
    step();
    cfg_start_i = '0;
    step();
    n = 0; eots = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (req_o && gnt_i) begin
        exp_c = n % N;
        chk("rr_order", req_ch_o, exp_c);
        chk("rr_addr", req_addr_o, 32'h100 * exp_c + cnt[exp_c]);
        cnt[exp_c]++;
        n++;
      end
      step();
      for (int c = 0; c < N; c++)
        if (eot_o[c]) begin
          chk("rr_eot_after_4th", cnt[c], 4);
          eots++;
        end
    end
    chk("rr_total_beats", n, 16);
    chk("rr_total_eots", eots, 4);
    chk("rr_idle", busy_o, 0);

    // Single-channel vector table with gnt tied high.
    for (int v = 0; v < 5; v++) begin
      set_cfg(vt[v].ch, vt[v].addr, vt[v].size, vt[v].ds, 1'b0);
      ch_ready_i = '1;
      gnt_i = 1'b1;
      cfg_start_i[vt[v].ch] = 1'b1;
      step();
      cfg_start_i = '0;
      chk("vec_lat1_req", req_o, 0);
      chk("vec_busy", busy_o[vt[v].ch], 1);
      step();
      chk("vec_lat2_req", req_o, 1);
      chk("vec_first_addr", req_addr_o, vt[v].addr);
      beats = 0; eots = 0; last_gnt = -1; eot_cyc = -2; last_addr = '0;
      exp_left = vt[v].size;
      for (int cyc = 0; cyc < 30; cyc++) begin
        if (req_o && gnt_i) begin
          beats++;
          last_addr = req_addr_o;
          last_gnt = cyc;
          exp_left = (exp_left > bbytes(vt[v].ds)) ? exp_left - bbytes(vt[v].ds) : 0;
        end
        step();
        if (eot_o[vt[v].ch]) begin
          eots++;
          eot_cyc = cyc;
        end
        chk("vec_bytes_left", bytes_left_o[vt[v].ch*SW +: SW], exp_left);
      end
      chk("vec_nbeats", beats, vt[v].nbeats);
      chk("vec_last_addr", last_addr, vt[v].last_addr);
      chk("vec_eot_count", eots, 1);
      chk("vec_eot_timing", eot_cyc, last_gnt);
      chk("vec_busy_end", busy_o, 0);
    end

    // Continuous mode on ch2, then stop while its request is held.
    set_cfg(2, 32'h3000, 4, 2'd2, 1'b1);
    gnt_i = 1'b1;
    cfg_start_i[2] = 1'b1;
    step();
    cfg_start_i = '0;
    step();
    n = 0; eots = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (req_o && gnt_i) begin
        chk("cont_addr", req_addr_o, 32'h3000);
        n++;
      end
      step();
      if (eot_o[2]) eots++;
    end
    chk("cont_beats", n, 3);
    chk("cont_eots", eots, 3);
    chk("cont_busy", busy_o[2], 1);
    chk("cont_reload_left", bytes_left_o[2*SW +: SW], 4);
    gnt_i = 1'b0;
    wait_req(4);
    chk("stop_held_ch", req_ch_o, 2);
    cfg_stop_i[2] = 1'b1;
    step();
    cfg_stop_i = '0;
    cfg_cont_i = '0;
    chk("stop_req_kept", req_o, 1);
    chk("stop_busy_kept", busy_o[2], 1);
    step();
    chk("stop_req_kept2", req_o, 1);
    gnt_i = 1'b1;
    step();
    chk("stop_busy_gone", busy_o[2], 0);
    chk("stop_no_eot", eot_o[2], 0);
    chk("stop_req_gone", req_o, 0);
    step();
    chk("stop_no_new_req", req_o, 0);

    // Zero-size start and start+stop collision.
    set_cfg(1, 32'h4000, 0, 2'd2, 1'b0);
    cfg_start_i[1] = 1'b1;
    step();
    cfg_start_i = '0;
    chk("zero_eot", eot_o[1], 1);
    chk("zero_busy", busy_o[1], 0);
    step();
    chk("zero_eot_once", eot_o[1], 0);
    for (int k = 0; k < 3; k++) begin
      chk("zero_no_req", req_o, 0);
      step();
    end
    set_cfg(3, 32'h5000, 8, 2'd2, 1'b0);
    cfg_start_i[3] = 1'b1;
    cfg_stop_i[3]  = 1'b1;
    step();
    cfg_start_i = '0;
    cfg_stop_i  = '0;
    chk("collide_busy", busy_o[3], 0);
    step();
    chk("collide_no_req", req_o, 0);
    chk("collide_no_eot", eot_o[3], 0);

    // Asynchronous reset with a request held on the port.
    set_cfg(1, 32'h6000, 16, 2'd0, 1'b0);
    set_cfg(2, 32'h7000, 16, 2'd0, 1'b0);
    gnt_i = 1'b0;
    cfg_start_i = 4'b0110;
    step();
    cfg_start_i = '0;
    wait_req(5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", req_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_left", bytes_left_o, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < N; c++) set_cfg(c, 32'h8000 + 32'h10 * c, 4, 2'd2, 1'b0);
    gnt_i = 1'b1;
    cfg_start_i = '1;
    step();
    cfg_start_i = '0;
    step();
    chk("arst_first_req", req_o, 1);
    chk("arst_first_ch", req_ch_o, 0);
    wait_idle(100);

    // Random traffic against per-channel beat queues.
    do_reset();
    m_req = 1'b0;
    m_ch = 0;
    m_last = N - 1;
    for (int c = 0; c < N; c++) m_left[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy = N'($urandom);
      g   = 1'($urandom_range(1, 0));
      stv = '0;
      m_eot = '0;
      if (m_req && g) begin
        bt = q[m_ch].pop_front();
        if (q[m_ch].size() == 0) begin
          m_left[m_ch] = 0;
          m_eot[m_ch] = 1'b1;
        end else begin
          m_left[m_ch] -= bbytes(bt.ds);
        end
        m_req = 1'b0;
      end else if (!m_req) begin
        for (int k = 1; k <= N; k++) begin
          ci = (m_last + k) % N;
          if (!m_req && q[ci].size() > 0 && rdy[ci]) begin
            m_req = 1'b1;
            m_ch = ci;
            m_last = ci;
          end
        end
      end
      for (int c = 0; c < N; c++) begin
        if (q[c].size() == 0 && !(m_eot[c]) && $urandom_range(5, 0) == 0) begin
          stv[c] = 1'b1;
          ra  = $urandom;
          sz  = $urandom_range(12, 0);
          rds = 2'($urandom_range(3, 0));
          set_cfg(c, ra, sz, rds, 1'b0);
          if (sz == 0) begin
            m_eot[c] = 1'b1;
            m_left[c] = 0;
          end else begin
            m_left[c] = sz;
            bsz = bbytes(rds);
            nb = (sz + bsz - 1) / bsz;
            for (int k = 0; k < nb; k++) begin
              bt.addr = ra + 32'(k * bsz);
              bt.ds = rds;
              q[c].push_back(bt);
            end
          end
        end
      end
      cfg_start_i = stv;
      ch_ready_i  = rdy;
      gnt_i       = g;
      step();
      cfg_start_i = '0;
      for (int c = 0; c < N; c++) bvec[c] = (q[c].size() > 0);
      chk("rnd_req", req_o, m_req);
      if (m_req && req_o) begin
        chk("rnd_ch", req_ch_o, m_ch);
        chk("rnd_addr", req_addr_o, q[m_ch][0].addr);
        chk("rnd_ds", req_datasize_o, q[m_ch][0].ds);
      end
      chk("rnd_busy", busy_o, bvec);
      chk("rnd_eot", eot_o, m_eot);
      for (int c = 0; c < N; c++) chk("rnd_left", bytes_left_o[c*SW +: SW], m_left[c]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
